// File: rtl/shift_add_mul_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier sequencing one RCA adder.
// Optional MUL_ZERO_SKIP_EN: a zero operand finishes straight from IDLE.

module RCA (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       Carry_in,
  output logic [7:0] s,
  output logic       Carry_out
);
  logic [8:0] c;
  assign c[0] = Carry_in;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign Carry_out = c[8];
endmodule

module shift_add_mul_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] m_q, a_q, q_q;
  logic       c_q;
  logic [2:0] cnt;
  logic [7:0] sum, add_a;
  logic       cout, add_c, zero_skip;

  RCA u_rca (
    .x        (a_q),
    .y        (m_q),
    .Carry_in (1'b0),
    .s        (sum),
    .Carry_out(cout)
  );

  // Conditional add selected by the multiplier LSB.
  assign add_a = q_q[0] ? sum  : a_q;
  assign add_c = q_q[0] ? cout : c_q;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_skip = (multiplicand == 8'd0) || (multiplier == 8'd0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_skip ? DONE : CALC;
      CALC:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Flags registered from the next state so they align with it.
      busy <= (state_nxt == CALC);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          m_q <= multiplicand;
          q_q <= multiplier;
          a_q <= '0;
          c_q <= 1'b0;
          cnt <= '0;
          if (zero_skip) product <= '0;
        end
        CALC: begin
          a_q <= {add_c, add_a[7:1]};
          q_q <= {add_a[0], q_q[7:1]};
          c_q <= 1'b0;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) product <= {add_c, add_a, q_q[7:1]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Randomized self-checking bench for shift_add_mul_ctrl against a plain a*b model.
module tb_shift_add_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy, done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;

  shift_add_mul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // Expected negedge index of done, counting negedge 1 as the one right after E0.
  function automatic int exp_k(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 9;
  endfunction

  function automatic int exp_busy(input logic [7:0] a, input logic [7:0] b);
    return (exp_k(a, b) == 1) ? 0 : 8;
  endfunction

  // Issue one request and observe it; operands are scrambled once accepted.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         output int k_done, output int bcnt, output logic [15:0] p);
    @(negedge clk);
    multiplicand = a; multiplier = b; start = 1'b1;
    @(posedge clk);
    k_done = 0; bcnt = 0; p = 'x;
    for (int k = 1; k <= 20 && k_done == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
      end
      if (busy) bcnt++;
      if (done) begin k_done = k; p = product; end
    end
  endtask

  task automatic check_mul(input string name, input logic [7:0] a, input logic [7:0] b);
    int kd, bc;
    logic [15:0] p, want;
    want = 16'(a) * 16'(b);
    run_mul(a, b, kd, bc, p);
    checks++;
    if (kd != exp_k(a, b)) begin
      errors++;
      $display("FAIL %s latency: got negedge %0d, want %0d", name, kd, exp_k(a, b));
    end
    checks++;
    if (p !== want) begin
      errors++;
      $display("FAIL %s product: got %h, want %h", name, p, want);
    end
    checks++;
    if (bc != exp_busy(a, b)) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d, want %0d", name, bc, exp_busy(a, b));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || product !== want) begin
        errors++;
        $display("FAIL %s hold: done=%b product=%h, want done=0 product=%h", name, done, product, want);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_mul("13x11", 8'd13, 8'd11);
    check_mul("255x255", 8'd255, 8'd255);
    check_mul("128x2", 8'd128, 8'd2);
    check_mul("0x200", 8'd0, 8'd200);
    check_mul("77x0", 8'd77, 8'd0);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 3) a = 8'd0;
      check_mul("random", a, b);
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    logic [15:0] p0, p1;
    d0 = 0; d1 = 0; p0 = 'x; p1 = 'x;
    @(negedge clk);
    multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin multiplicand = 8'd7; multiplier = 8'd9; end
      if (done) begin
        if (d0 == 0) begin d0 = k; p0 = product; end
        else if (d1 == 0) begin d1 = k; p1 = product; start = 1'b0; end
      end
    end
    start = 1'b0;
    checks++;
    if (d0 != 9 || p0 !== 16'h000F) begin
      errors++;
      $display("FAIL b2b first: negedge %0d product %h, want 9 000f", d0, p0);
    end
    checks++;
    if (d1 != 19 || p1 !== 16'h003F) begin
      errors++;
      $display("FAIL b2b second: negedge %0d product %h, want 19 003f", d1, p1);
    end
  endtask

  task automatic test_ignore_start();
    int kd, extra;
    logic [15:0] p;
    kd = 0; extra = 0; p = 'x;
    @(negedge clk);
    multiplicand = 8'd6; multiplier = 8'd7; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; multiplicand = 8'd50; multiplier = 8'd60; end
      if (k == 4) start = 1'b0;
      if (k == 5) begin multiplicand = 8'd200; multiplier = 8'd3; end
      if (done) begin
        if (kd == 0) begin kd = k; p = product; end
        else extra++;
      end
    end
    checks++;
    if (kd != 9 || p !== 16'h002A || extra != 0) begin
      errors++;
      $display("FAIL ignore start: negedge %0d product %h extra %0d, want 9 002a 0", kd, p, extra);
    end
  endtask

  task automatic test_mid_reset();
    int stray;
    stray = 0;
    @(negedge clk);
    multiplicand = 8'd100; multiplier = 8'd100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
      errors++;
      $display("FAIL mid reset: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid reset stray done: got %0d pulses, want 0", stray);
    end
    check_mul("100x100", 8'd100, 8'd100);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
